// File: rtl/radix4_booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : radix4_booth_seq_multiplier
// Purpose  : Sequential radix-4 Booth multiplier. It retires two multiplier
//            bits per cycle and returns the full 2*WIDTH-bit product. The
//            signedness of each operand is chosen per operation, and a
//            start/ready/done handshake controls each transfer.
// Options  : MULT_ZERO_SKIP_EN - when defined, an operation with a zero
//            operand finishes one cycle after it is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module radix4_booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ITER  = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(ITER);
  localparam int ACC_W = 2 * WIDTH + 4;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("radix4_booth_seq_multiplier: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH+1:0]   a_ext;     // multiplicand extended to WIDTH+2 bits
  logic [WIDTH+2:0]   b_sh;      // {extended multiplier, b[-1]}, shifted 2 per step
  logic [ACC_W-1:0]   acc;
  logic [WIDTH+1:0]   a_dbl;
  logic [WIDTH+1:0]   pp;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   acc_next;
  logic               accept;
`ifdef MULT_ZERO_SKIP_EN
  logic               zero_op;
`endif

  // ready is high exactly in IDLE and DONE, so it gates acceptance directly
  assign accept   = start & ready;
  assign a_dbl    = {a_ext[WIDTH:0], 1'b0};

  // Partial products are added at bit WIDTH+2. After ITER shifts of two
  // bits each, the total weight is exact and the accumulator never drops a
  // nonzero bit.
  assign sum      = {acc[ACC_W-1:WIDTH+2] + pp, acc[WIDTH+1:0]};
  assign acc_next = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};

  // Booth digit selection from the low triplet of the shifting multiplier
  always_comb begin
    pp = '0;
    case (b_sh[2:0])
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_dbl;
      3'b100:         pp = -a_dbl;
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
  end

  // Operand capture on accept, then one Booth step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ext <= '0;
      b_sh  <= '0;
      acc   <= '0;
`ifdef MULT_ZERO_SKIP_EN
      zero_op <= 1'b0;
`endif
    end else if (accept) begin
      a_ext <= a_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                        : {2'b00, multiplicand};
      b_sh  <= b_signed ? {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0}
                        : {2'b00, multiplier, 1'b0};
      acc   <= '0;
`ifdef MULT_ZERO_SKIP_EN
      zero_op <= (multiplicand == '0) || (multiplier == '0);
`endif
    end else if (state == S_RUN) begin
      acc  <= acc_next;
      b_sh <= {2'b00, b_sh[WIDTH+2:2]};
    end
  end

  // Control FSM with registered handshake outputs and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            count <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        S_RUN: begin
`ifdef MULT_ZERO_SKIP_EN
          if (zero_op) begin
            state   <= S_DONE;
            count   <= '0;
            busy    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b1;
            product <= '0;
          end else
`endif
          if (count == CNT_W'(ITER - 1)) begin
            state   <= S_DONE;
            count   <= '0;
            busy    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b1;
            product <= acc_next[2*WIDTH-1:0];
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_RUN;
            count <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_radix4_booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_radix4_booth_seq_multiplier
// Purpose  : Scoreboard bench for radix4_booth_seq_multiplier. It drives a
//            WIDTH=32 instance and a WIDTH=8 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radix4_booth_seq_multiplier;

`ifdef MULT_ZERO_SKIP_EN
  localparam int ZLAT32 = 1;
  localparam int ZLAT8  = 1;
`else
  localparam int ZLAT32 = 17;
  localparam int ZLAT8  = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, a_s, b_s;
  logic [31:0] ma, mb;
  logic        ready, busy, done;
  logic [63:0] product;

  logic        start8, a_s8, b_s8;
  logic [7:0]  ma8, mb8;
  logic        ready8, busy8, done8;
  logic [15:0] product8;

  radix4_booth_seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .a_signed(a_s), .b_signed(b_s),
    .multiplicand(ma), .multiplier(mb), .ready(ready), .busy(busy),
    .done(done), .product(product)
  );

  radix4_booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_signed(a_s8), .b_signed(b_s8),
    .multiplicand(ma8), .multiplier(mb8), .ready(ready8), .busy(busy8),
    .done(done8), .product(product8)
  );

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          c0;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   busy_run32 = 0;
  int   busy_run8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic as_, input logic bs_,
                                       input logic [7:0] a, input logic [7:0] b);
    longint x, y, p;
    x = as_ ? longint'($signed(a)) : longint'(a);
    y = bs_ ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[15:0];
  endfunction

  // Monitor for the 32-bit instance
  always @(negedge clk) begin : mon32
    exp_t e;
    if (busy) busy_run32++;
    if (done) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done32: got done=1 product=%h expected no done", product);
      end else begin
        e = q32.pop_front();
        check({e.name, "_product"}, product, e.prod);
        check({e.name, "_latency"}, 64'(cyc - e.c0), 64'(e.lat));
        check({e.name, "_busy_cycles"}, 64'(busy_run32), 64'(e.lat));
      end
      busy_run32 = 0;
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin : mon8
    exp_t e;
    if (busy8) busy_run8++;
    if (done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done8: got done=1 product=%h expected no done", product8);
      end else begin
        e = q8.pop_front();
        check({e.name, "_product"}, {48'b0, product8}, e.prod);
        check({e.name, "_latency"}, 64'(cyc - e.c0), 64'(e.lat));
      end
      busy_run8 = 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      busy_run32 = 0;
      busy_run8  = 0;
    end
  end

  task automatic issue32(input logic as_, input logic bs_, input logic [31:0] a_,
                         input logic [31:0] b_, input logic [63:0] exp, input int lat,
                         input string name, input bit push, input bit keep);
    exp_t e;
    int   g = 0;
    @(negedge clk);
    a_s = as_; b_s = bs_; ma = a_; mb = b_; start = 1'b1;
    while (!ready && g < 200) begin @(negedge clk); g++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL %s_accept_timeout: got ready=0 expected ready=1", name);
      start = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) begin
      e.prod = exp; e.lat = lat; e.c0 = cyc; e.name = name;
      q32.push_back(e);
    end
    if (!keep) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic issue8(input logic as_, input logic bs_, input logic [7:0] a_,
                        input logic [7:0] b_, input logic [15:0] exp, input int lat,
                        input string name);
    exp_t e;
    int   g = 0;
    @(negedge clk);
    a_s8 = as_; b_s8 = bs_; ma8 = a_; mb8 = b_; start8 = 1'b1;
    while (!ready8 && g < 100) begin @(negedge clk); g++; end
    if (!ready8) begin
      checks++; errors++;
      $display("FAIL %s_accept_timeout: got ready=0 expected ready=1", name);
      start8 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.prod = {48'b0, exp}; e.lat = lat; e.c0 = cyc; e.name = name;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    while ((q32.size() != 0 || q8.size() != 0) && g < 200) begin
      @(negedge clk); g++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, q32.size() + q8.size());
      q32.delete();
      q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got no completion expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic       as_r, bs_r;
    logic [7:0] ar, br;
    rst = 1'b1;
    start = 1'b0; a_s = 1'b0; b_s = 1'b0; ma = '0; mb = '0;
    start8 = 1'b0; a_s8 = 1'b0; b_s8 = 1'b0; ma8 = '0; mb8 = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'b0, ready}, 64'd1);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst = 1'b0;

    issue32(1'b0, 1'b0, 32'd5678982, 32'd2502684, 64'd14212697387688, 17, "unsigned_basic", 1'b1, 1'b0);
    issue32(1'b1, 1'b1, 32'd24, 32'hFFFFFFE8, 64'hFFFFFFFF_FFFFFDC0, 17, "signed_24xm24", 1'b1, 1'b0);
    issue32(1'b1, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 17, "signed_min_sq", 1'b1, 1'b0);
    issue32(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000001, 17, "mixed_sa_ub", 1'b1, 1'b0);
    issue32(1'b0, 1'b1, 32'd2, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFFA, 17, "mixed_ua_sb", 1'b1, 1'b0);
    issue32(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 17, "unsigned_max_sq", 1'b1, 1'b0);
    drain("directed");

    // start pulse during RUN must be ignored
    issue32(1'b0, 1'b0, 32'd1000, 32'd1000, 64'd1000000, 17, "ignore_start", 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    ma = 32'd5; mb = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignore");

    // start held high: second operation accepted in the DONE cycle
    issue32(1'b0, 1'b0, 32'h12345678, 32'h10, 64'h1_23456780, 17, "b2b_first", 1'b1, 1'b1);
    issue32(1'b0, 1'b0, 32'd3, 32'd5, 64'd15, 17, "b2b_second", 1'b1, 1'b0);
    drain("b2b");

    // reset in the middle of RUN abandons the operation
    issue32(1'b0, 1'b0, 32'd100, 32'd3, 64'd300, 17, "aborted", 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_ready", {63'b0, ready}, 64'd1);
    check("midrst_product", product, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue32(1'b0, 1'b0, 32'd7, 32'd9, 64'd63, 17, "after_reset", 1'b1, 1'b0);
    issue32(1'b0, 1'b0, 32'd0, 32'd12345, 64'd0, ZLAT32, "zero_operand", 1'b1, 1'b0);
    drain("tail32");

    // 8-bit instance: directed boundary then a random sweep against the model
    issue8(1'b1, 1'b1, 8'h80, 8'h7F, 16'hC080, 5, "w8_min_x_max");
    issue8(1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 5, "w8_unsigned_max");
    issue8(1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFF01, 5, "w8_mixed");
    for (int i = 0; i < 16; i++) begin
      as_r = 1'($urandom_range(0, 1));
      bs_r = 1'($urandom_range(0, 1));
      ar = 8'($urandom_range(0, 255));
      br = 8'($urandom_range(0, 255));
      issue8(as_r, bs_r, ar, br, ref8(as_r, bs_r, ar, br),
             (ar == 8'd0 || br == 8'd0) ? ZLAT8 : 5, "w8_rand");
    end
    drain("tail8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
